seq_alu: RTL and testbench
==========================

# seq_alu

Parametrised, multi-cycle arithmetic/logic unit for the mini CPU datapath; the successor to the combinational ALU. Performs the same twelve operations plus subtract over a configurable `WIDTH`. Single-cycle ops complete in one clock; signed multiply and signed divide run iteratively behind a start/busy/done handshake. Results land in registered low/high outputs that feed the Z register pair.

## Interface
- `WIDTH`, 32: operand width; even, ≥ 8. `SHW` = clog2(`WIDTH`) is derived internally.
- `clock`  in  1  system clock; all state changes on the rising edge.
- `reset_n`  in  1  synchronous, active-low reset, sampled on the rising edge of `clock`.
- `start`  in  1  request; accepted only when `busy`=0.
- `op`  in  5  operation code, captured on accept.
- `A`, `B`  in  `WIDTH` each  operands, captured on accept.
- `busy`  out  1  high while a multi-cycle op is in progress.
- `done`  out  1  one-cycle pulse; results are valid from this cycle.
- `Zlowout`  out  `WIDTH`  low result word; quotient for divide.
- `Zhighout`  out  `WIDTH`  high result word; remainder for divide.
- `carry`, `overflow`, `zero`, `illegal`  out  1 each  status flags, updated with `done`.

## Operation
- Op codes:
  - 0 add; 1 and; 2 or; 3 shl; 4 shr (logical); 5 sra; 6 rol; 7 ror.
  - 8 not A; 9 negate A; 10 signed multiply; 11 signed divide; 12 sub (A−B).
  - 13–31 are illegal.
- Shift and rotate amount is `B[SHW-1:0]`. Upper bits of B are ignored.
- Single-cycle ops (all except 10 and 11): `Zhighout` = 0.
- Add/sub flags:
  - `carry` = carry out of bit `WIDTH`−1; for sub, carry=1 means no borrow.
  - `overflow` = signed overflow.
  - Both flags are 0 for all other ops.
- `zero` = 1 iff every bit of {`Zhighout`,`Zlowout`} is 0.
- Multiply: two's-complement `WIDTH`×`WIDTH` → 2·`WIDTH`, radix-2 Booth, one step per cycle. Result is {`Zhighout`,`Zlowout`}.
- Divide: signed restoring division on magnitudes, then a sign fixup.
  - Quotient truncates toward zero.
  - Remainder takes the sign of A.
- Divide by zero (B=0): completes in one cycle with quotient all-ones, remainder = A, `illegal`=1.
- Most-negative ÷ −1: quotient = most-negative, remainder 0, `overflow`=1.
- Illegal op: completes in one cycle; both result words 0, `illegal`=1, `zero`=1.
- FSM states:
  - IDLE → on accept of a single-cycle op, divide by zero, or illegal op: back to IDLE with `done`.
  - IDLE → MUL on accept of op 10; MUL → IDLE with `done` after `WIDTH` steps.
  - IDLE → DIV on accept of op 11 with B≠0; DIV → FIX after `WIDTH` steps; FIX → IDLE with `done`.
- `start` while `busy`=1 is ignored. The operation in flight is unaffected.
- Outputs and flags hold their values until the next `done`.

## Timing
- Start accepted at edge N:
  - single-cycle op: `done`=1 and results valid after edge N+1.
  - multiply: `busy`=1 for `WIDTH` cycles; `done` after edge N+`WIDTH`+1.
  - divide: `busy`=1 for `WIDTH`+1 cycles; `done` after edge N+`WIDTH`+2.
- `busy` is 0 in the `done` cycle. A new `start` may be accepted in that same cycle (back-to-back).
- Reset values: `Zlowout`=0, `Zhighout`=0, `busy`=0, `done`=0, all four flags 0, FSM=IDLE.
- Reset asserted mid-operation aborts the op. No `done` is produced for it.

## Configuration
- `SEQ_ALU_DIV_EN` defined: the divider datapath and the DIV/FIX states are built.
- Undefined: op 11 is treated as illegal (one-cycle `done`, zero result, `illegal`=1). No divider logic is synthesised.

## Test plan
- Reset, then A=0x7FFFFFFF, B=1, op 0 → `Zlowout`=0x80000000, `overflow`=1, `carry`=0, `done` one cycle after accept.
- A=0xFFFFFFFD (−3), B=7, op 10 → `Zlowout`=0xFFFFFFEB, `Zhighout`=0xFFFFFFFF, `done` exactly 33 cycles after accept; `busy` high for 32 cycles.
- With `SEQ_ALU_DIV_EN`: A=0xFFFFFFF9 (−7), B=2, op 11 → `Zlowout`=0xFFFFFFFD, `Zhighout`=0xFFFFFFFF, `done` 34 cycles after accept. Then B=0 → one-cycle `done`, `Zlowout`=0xFFFFFFFF, `illegal`=1.
- Issue op 10 with A=5, B=6. During `busy`, pulse `start` with op 0 → exactly one `done`, with `Zlowout`=30. Issue op 0 again in the `done` cycle → accepted; its `done` follows one cycle later.
- A=0x80000001, B=36, op 6 (rol by 4) → `Zlowout`=0x00000018. Op 5 with A=0x80000000, B=4 → `Zlowout`=0xF8000000. Op 20 → `illegal`=1, `zero`=1.
- Assert `reset_n`=0 ten cycles into a multiply → next cycle `busy`=0 and outputs are 0. No `done` ever appears for the aborted op.

Source files
------------

// File: rtl/seq_alu.sv
// Multi-cycle ALU: single-cycle logic/arith ops, Booth multiply, restoring divide.
// Divider datapath and DIV/FIX states exist only when SEQ_ALU_DIV_EN is defined.
module seq_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [4:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Zlowout,
  output logic [WIDTH-1:0] Zhighout,
  output logic             carry,
  output logic             overflow,
  output logic             zero,
  output logic             illegal
);
  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);
  localparam logic [SHW-1:0] CNT_ONE  = SHW'(1);

  localparam logic [4:0] OP_ADD = 5'd0,  OP_AND = 5'd1,  OP_OR  = 5'd2,  OP_SHL = 5'd3;
  localparam logic [4:0] OP_SHR = 5'd4,  OP_SRA = 5'd5,  OP_ROL = 5'd6,  OP_ROR = 5'd7;
  localparam logic [4:0] OP_NOT = 5'd8,  OP_NEG = 5'd9,  OP_MUL = 5'd10, OP_DIV = 5'd11;
  localparam logic [4:0] OP_SUB = 5'd12;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1
`ifdef SEQ_ALU_DIV_EN
    , S_DIV = 2'd2
    , S_FIX = 2'd3
`endif
  } state_t;

  state_t state_q, state_d;
  logic req_q, req_d;
  logic [4:0] op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [SHW-1:0] cnt_q, cnt_d;
  logic [2*WIDTH+1:0] mul_q, mul_d, mul_next;
  logic [WIDTH:0] mul_hi, mul_sum, mcand_x;
  logic [WIDTH-1:0] zlo_q, zlo_d, zhi_q, zhi_d;
  logic carry_q, carry_d, ovf_q, ovf_d, zero_q, zero_d, ill_q, ill_d, done_q, done_d;
  logic launch, accept;

  logic [SHW-1:0] sh;
  logic [WIDTH:0] add_full, sub_full;
  logic [WIDTH-1:0] alu_lo;
  logic alu_c, alu_v, alu_ill;

`ifdef SEQ_ALU_DIV_EN
  logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic [WIDTH-1:0] a_mag, b_mag, quo_fix, rem_fix;
  logic [WIDTH:0] r_sh, r_diff;
  logic div_ovf;
`endif

  // Operands are registered on accept; the FSM acts on them one edge later.
  // A start arriving while a multi-cycle op is being launched is ignored.
  always_comb begin
    launch = req_q && (op_q == OP_MUL);
`ifdef SEQ_ALU_DIV_EN
    if (req_q && (op_q == OP_DIV) && (b_q != '0)) launch = 1'b1;
`endif
  end

  assign busy   = (state_q != S_IDLE);
  assign accept = start && (state_q == S_IDLE) && !launch;

  assign sh       = b_q[SHW-1:0];
  assign add_full = {1'b0, a_q} + {1'b0, b_q};
  assign sub_full = {1'b0, a_q} + {1'b0, ~b_q} + (WIDTH+1)'(1);

  always_comb begin
    alu_lo  = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_ill = 1'b0;
    case (op_q)
      OP_ADD: begin
        alu_lo = add_full[WIDTH-1:0];
        alu_c  = add_full[WIDTH];
        alu_v  = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (add_full[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_SUB: begin
        alu_lo = sub_full[WIDTH-1:0];
        alu_c  = sub_full[WIDTH];
        alu_v  = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (sub_full[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_AND: alu_lo = a_q & b_q;
      OP_OR:  alu_lo = a_q | b_q;
      OP_SHL: alu_lo = a_q << sh;
      OP_SHR: alu_lo = a_q >> sh;
      OP_SRA: alu_lo = $signed(a_q) >>> sh;
      // A shift by WIDTH yields zero, so a rotate amount of 0 needs no special case.
      OP_ROL: alu_lo = (a_q << sh) | (a_q >> ((SHW+1)'(WIDTH) - {1'b0, sh}));
      OP_ROR: alu_lo = (a_q >> sh) | (a_q << ((SHW+1)'(WIDTH) - {1'b0, sh}));
      OP_NOT: alu_lo = ~a_q;
      OP_NEG: alu_lo = -a_q;
      default: alu_ill = 1'b1;
    endcase
  end

  // Radix-2 Booth step; the accumulator carries one guard bit for the most-negative multiplicand.
  assign mcand_x = {a_q[WIDTH-1], a_q};
  assign mul_hi  = mul_q[2*WIDTH+1:WIDTH+1];
  always_comb begin
    case (mul_q[1:0])
      2'b01:   mul_sum = mul_hi + mcand_x;
      2'b10:   mul_sum = mul_hi - mcand_x;
      default: mul_sum = mul_hi;
    endcase
    mul_next = $signed({mul_sum, mul_q[WIDTH:0]}) >>> 1;
  end

`ifdef SEQ_ALU_DIV_EN
  assign a_mag   = a_q[WIDTH-1] ? -a_q : a_q;
  assign b_mag   = b_q[WIDTH-1] ? -b_q : b_q;
  assign r_sh    = {rem_q, quo_q[WIDTH-1]};
  assign r_diff  = r_sh - {1'b0, dvs_q};
  assign quo_fix = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) ? -quo_q : quo_q;
  assign rem_fix = a_q[WIDTH-1] ? -rem_q : rem_q;
  assign div_ovf = (a_q == {1'b1, {(WIDTH-1){1'b0}}}) && (b_q == '1);
`endif

  always_comb begin
    state_d = state_q;
    req_d   = 1'b0;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    mul_d   = mul_q;
`ifdef SEQ_ALU_DIV_EN
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
`endif
    zlo_d   = zlo_q;
    zhi_d   = zhi_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    ill_d   = ill_q;
    done_d  = 1'b0;

    if (accept) begin
      req_d = 1'b1;
      op_d  = op;
      a_d   = A;
      b_d   = B;
    end

    case (state_q)
      S_IDLE: begin
        if (req_q) begin
          if (op_q == OP_MUL) begin
            state_d = S_MUL;
            mul_d   = {{(WIDTH+1){1'b0}}, b_q, 1'b0};
            cnt_d   = CNT_LAST;
          end
`ifdef SEQ_ALU_DIV_EN
          else if ((op_q == OP_DIV) && (b_q != '0)) begin
            state_d = S_DIV;
            rem_d   = '0;
            quo_d   = a_mag;
            dvs_d   = b_mag;
            cnt_d   = CNT_LAST;
          end else if (op_q == OP_DIV) begin
            done_d  = 1'b1;
            zlo_d   = '1;
            zhi_d   = a_q;
            carry_d = 1'b0;
            ovf_d   = 1'b0;
            ill_d   = 1'b1;
          end
`endif
          else begin
            done_d  = 1'b1;
            zlo_d   = alu_lo;
            zhi_d   = '0;
            carry_d = alu_c;
            ovf_d   = alu_v;
            ill_d   = alu_ill;
          end
        end
      end
      S_MUL: begin
        mul_d = mul_next;
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == '0) begin
          state_d        = S_IDLE;
          done_d         = 1'b1;
          {zhi_d, zlo_d} = mul_next[2*WIDTH:1];
          carry_d        = 1'b0;
          ovf_d          = 1'b0;
          ill_d          = 1'b0;
        end
      end
`ifdef SEQ_ALU_DIV_EN
      S_DIV: begin
        if (!r_diff[WIDTH]) begin
          rem_d = r_diff[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = r_sh[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == '0) state_d = S_FIX;
      end
      S_FIX: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        zlo_d   = quo_fix;
        zhi_d   = rem_fix;
        carry_d = 1'b0;
        ovf_d   = div_ovf;
        ill_d   = 1'b0;
      end
`endif
      default: state_d = S_IDLE;
    endcase

    if (done_d) zero_d = ~|{zhi_d, zlo_d};
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      req_q   <= 1'b0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      mul_q   <= '0;
`ifdef SEQ_ALU_DIV_EN
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
`endif
      zlo_q   <= '0;
      zhi_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
      ill_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      mul_q   <= mul_d;
`ifdef SEQ_ALU_DIV_EN
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
`endif
      zlo_q   <= zlo_d;
      zhi_q   <= zhi_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
      ill_q   <= ill_d;
      done_q  <= done_d;
    end
  end

  assign done     = done_q;
  assign Zlowout  = zlo_q;
  assign Zhighout = zhi_q;
  assign carry    = carry_q;
  assign overflow = ovf_q;
  assign zero     = zero_q;
  assign illegal  = ill_q;
endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu (WIDTH=32): scoreboard of model results checked on each done.
module tb_seq_alu;
  localparam int W = 32;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  logic clock = 1'b0;
  logic reset_n, start;
  logic [4:0] op;
  logic [W-1:0] A, B;
  logic busy, done, carry, overflow, zero, illegal;
  logic [W-1:0] Zlowout, Zhighout;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string tag;
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic c, v, z, ill;
  } exp_t;
  exp_t sb[$];

  seq_alu #(.WIDTH(W)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .op(op), .A(A), .B(B),
    .busy(busy), .done(done), .Zlowout(Zlowout), .Zhighout(Zhighout),
    .carry(carry), .overflow(overflow), .zero(zero), .illegal(illegal)
  );

  always #5 clock = ~clock;

  initial begin
    #400000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "time limit");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic exp_t model(input string tag, input logic [4:0] o,
                                 input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    longint sa, sbv, r;
    logic [63:0] p;
    int sh;
    e.tag = tag; e.lo = '0; e.hi = '0; e.c = 1'b0; e.v = 1'b0; e.ill = 1'b0;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    sh  = int'(b[4:0]);
    case (o)
      5'd0: begin
        e.lo = a + b;
        e.c  = (64'(a) + 64'(b)) >= 64'h1_0000_0000;
        r    = sa + sbv;
        e.v  = (r > SMAX) || (r < SMIN);
      end
      5'd12: begin
        e.lo = a - b;
        e.c  = (a >= b);
        r    = sa - sbv;
        e.v  = (r > SMAX) || (r < SMIN);
      end
      5'd1: e.lo = a & b;
      5'd2: e.lo = a | b;
      5'd3: e.lo = a << sh;
      5'd4: e.lo = a >> sh;
      5'd5: e.lo = 32'(sa >>> sh);
      5'd6: e.lo = (a << sh) | (a >> (32 - sh));
      5'd7: e.lo = (a >> sh) | (a << (32 - sh));
      5'd8: e.lo = ~a;
      5'd9: e.lo = 32'(-sa);
      5'd10: begin
        p = 64'(sa * sbv);
        e.lo = p[31:0];
        e.hi = p[63:32];
      end
`ifdef SEQ_ALU_DIV_EN
      5'd11: begin
        if (b == '0) begin
          e.lo = '1; e.hi = a; e.ill = 1'b1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          e.lo = a; e.hi = '0; e.v = 1'b1;
        end else begin
          e.lo = 32'(sa / sbv);
          e.hi = 32'(sa % sbv);
        end
      end
`endif
      default: e.ill = 1'b1;
    endcase
    e.z = ({e.hi, e.lo} == 64'd0);
    return e;
  endfunction

  task automatic check_result();
    exp_t e;
    chk("sb_has_entry", 64'(sb.size() != 0), 64'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({e.tag, "_lo"},  64'(Zlowout),  64'(e.lo));
      chk({e.tag, "_hi"},  64'(Zhighout), 64'(e.hi));
      chk({e.tag, "_c"},   64'(carry),    64'(e.c));
      chk({e.tag, "_v"},   64'(overflow), 64'(e.v));
      chk({e.tag, "_z"},   64'(zero),     64'(e.z));
      chk({e.tag, "_ill"}, 64'(illegal),  64'(e.ill));
      $display("txn %s lo=%h hi=%h c=%b v=%b z=%b ill=%b", e.tag, Zlowout, Zhighout,
               carry, overflow, zero, illegal);
    end
  endtask

  // Called half-way through a cycle; drives one request and waits for its done.
  task automatic run_op(input string tag, input logic [4:0] o,
                        input logic [W-1:0] a, input logic [W-1:0] b);
    int lat_exp, busy_exp, k, bcnt;
    if (o == 5'd10) begin
      lat_exp = W + 1; busy_exp = W;
    end
`ifdef SEQ_ALU_DIV_EN
    else if (o == 5'd11 && b != '0) begin
      lat_exp = W + 2; busy_exp = W + 1;
    end
`endif
    else begin
      lat_exp = 1; busy_exp = 0;
    end
    sb.push_back(model(tag, o, a, b));
    start = 1'b1; op = o; A = a; B = b;
    step();
    start = 1'b0;
    k = 0; bcnt = 0;
    while (k < 100) begin
      if (busy) bcnt++;
      step();
      k++;
      if (done) break;
    end
    chk({tag, "_latency"}, 64'(k), 64'(lat_exp));
    chk({tag, "_busy_cycles"}, 64'(bcnt), 64'(busy_exp));
    chk({tag, "_busy_in_done"}, 64'(busy), 64'd0);
    check_result();
  endtask

  initial begin
    int k, dones;
    reset_n = 1'b0; start = 1'b0; op = '0; A = '0; B = '0;
    repeat (3) step();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_lo", 64'(Zlowout), 64'd0);
    chk("rst_hi", 64'(Zhighout), 64'd0);
    chk("rst_flags", 64'({carry, overflow, zero, illegal}), 64'd0);
    reset_n = 1'b1;
    step();

    run_op("add_ovf", 5'd0, 32'h7FFF_FFFF, 32'h1);
    chk("add_ovf_const", 64'(Zlowout), 64'h8000_0000);
    run_op("add_carry", 5'd0, 32'hFFFF_FFFF, 32'h2);
    run_op("add_zero", 5'd0, 32'hFFFF_FFFF, 32'h1);
    run_op("sub_borrow", 5'd12, 32'd3, 32'd5);
    run_op("sub_ovf", 5'd12, 32'h8000_0000, 32'h1);
    run_op("sub_eq", 5'd12, 32'h1234_5678, 32'h1234_5678);

    run_op("mul_neg", 5'd10, 32'hFFFF_FFFD, 32'd7);
    chk("mul_neg_lo_const", 64'(Zlowout), 64'hFFFF_FFEB);
    chk("mul_neg_hi_const", 64'(Zhighout), 64'hFFFF_FFFF);
    run_op("mul_minmin", 5'd10, 32'h8000_0000, 32'h8000_0000);
    run_op("mul_minmax", 5'd10, 32'h8000_0000, 32'h7FFF_FFFF);
    run_op("mul_zero", 5'd10, 32'h0, 32'hDEAD_BEEF);

`ifdef SEQ_ALU_DIV_EN
    run_op("div_neg", 5'd11, 32'hFFFF_FFF9, 32'd2);
    run_op("div_by0", 5'd11, 32'h1234_5678, 32'd0);
    chk("div_by0_lo_const", 64'(Zlowout), 64'hFFFF_FFFF);
    run_op("div_minneg1", 5'd11, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("div_pos_neg", 5'd11, 32'd100, 32'hFFFF_FFF9);
    run_op("div_small", 5'd11, 32'd3, 32'd10);
`else
    run_op("div_disabled", 5'd11, 32'hFFFF_FFF9, 32'd2);
`endif

    run_op("rol4", 5'd6, 32'h8000_0001, 32'd36);
    chk("rol4_const", 64'(Zlowout), 64'h0000_0018);
    repeat (3) step();
    chk("hold_lo", 64'(Zlowout), 64'h0000_0018);
    chk("hold_done_low", 64'(done), 64'd0);
    run_op("sra4", 5'd5, 32'h8000_0000, 32'd4);
    chk("sra4_const", 64'(Zlowout), 64'hF800_0000);
    run_op("ill20", 5'd20, 32'hDEAD_BEEF, 32'h1);
    run_op("ill31", 5'd31, 32'h1, 32'h1);
    run_op("ror0", 5'd7, 32'hA5A5_0001, 32'hFFFF_FFE0);
    run_op("ror9", 5'd7, 32'h8765_4321, 32'd9);
    run_op("shl31", 5'd3, 32'h0000_0003, 32'd31);
    run_op("shr31", 5'd4, 32'h8000_0000, 32'd31);
    run_op("and", 5'd1, 32'hF0F0_1234, 32'h0FF0_FFFF);
    run_op("or", 5'd2, 32'hF000_0000, 32'h0000_000F);
    run_op("not", 5'd8, 32'hFFFF_FFFF, 32'h0);
    run_op("neg_min", 5'd9, 32'h8000_0000, 32'h0);
    run_op("neg", 5'd9, 32'd5, 32'h0);

    for (int i = 0; i < 8; i++) begin
      int r;
      logic [4:0] ro;
      r  = int'($urandom_range(0, 10));
      ro = (r == 10) ? 5'd12 : 5'(r);
      run_op($sformatf("rand%0d_op%0d", i, ro), ro, $urandom, $urandom);
    end

    // start pulsed while a multiply is busy must be ignored
    sb.push_back(model("mul_5x6", 5'd10, 32'd5, 32'd6));
    start = 1'b1; op = 5'd10; A = 32'd5; B = 32'd6;
    step();
    start = 1'b0;
    k = 0;
    while (k < 100) begin
      if (k == 5) begin
        start = 1'b1; op = 5'd0; A = 32'd100; B = 32'd1;
      end else begin
        start = 1'b0;
      end
      step();
      k++;
      if (done) break;
    end
    start = 1'b0;
    chk("mul_5x6_latency", 64'(k), 64'd33);
    check_result();
    chk("mul_5x6_lo_const", 64'(Zlowout), 64'd30);
    run_op("b2b_add", 5'd0, 32'd9, 32'd10);
    dones = 0;
    repeat (40) begin
      step();
      if (done) dones++;
    end
    chk("no_stray_done", 64'(dones), 64'd0);

    // reset in the middle of a multiply aborts it
    start = 1'b1; op = 5'd10; A = 32'd3; B = 32'd4;
    step();
    start = 1'b0;
    repeat (10) step();
    chk("pre_abort_busy", 64'(busy), 64'd1);
    reset_n = 1'b0;
    step();
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_lo", 64'(Zlowout), 64'd0);
    chk("abort_hi", 64'(Zhighout), 64'd0);
    chk("abort_flags", 64'({carry, overflow, zero, illegal}), 64'd0);
    reset_n = 1'b1;
    dones = 0;
    repeat (50) begin
      step();
      if (done) dones++;
    end
    chk("abort_no_done", 64'(dones), 64'd0);
    run_op("post_abort_add", 5'd0, 32'd1, 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
